fft_frame_streamer: RTL
=======================

FFT_FRAME_STREAMER -- requirements
Module: fft_frame_streamer

Interface
REQ-001 SHALL have parameter formatWidth, default 9, width of one packed float sample (sign/exp/sig).
REQ-002 SHALL have parameter NPOINT, default 32, FFT points per frame; legal values 4, 8, 16, 32, 64.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum cycles to wait for fft_done.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1 / in_ready output 1, the sample handshake.
REQ-007 SHALL have ports in_real, in_imag  input  formatWidth  one sample.
REQ-008 SHALL have port fft_size  output  11  constant NPOINT.
REQ-009 SHALL have port fft_start  output  1  core run request.
REQ-010 SHALL have ports vec_real, vec_imag  output  NPOINT*formatWidth  packed frame to core.
REQ-011 SHALL have ports core_real, core_imag  input  NPOINT*formatWidth  core result vectors.
REQ-012 SHALL have port fft_done  input  1  core completion level.
REQ-013 SHALL have ports out_valid output 1 / out_ready input 1, the result handshake.
REQ-014 SHALL have ports out_real, out_imag output formatWidth and out_last output 1, the result sample and last-of-frame flag.
REQ-015 SHALL have ports busy output 1 (state != IDLE) and timeout_err output 1 (sticky).

Function
REQ-016 SHALL implement the states IDLE, LOAD, RUN, DRAIN.
REQ-017 IDLE SHALL go to LOAD one cycle after reset release, and SHALL be re-entered only on timeout.
REQ-018 LOAD SHALL assert in_ready; each in_valid&in_ready transfer writes sample k (k = 0..NPOINT-1, counted by a log2(NPOINT)-bit counter) to vec bits [formatWidth*(k+1)-1 : formatWidth*k].
REQ-019 The LOAD counter SHALL wrap to 0 on the NPOINT-th transfer, and the next state SHALL be RUN.
REQ-020 RUN SHALL hold fft_start=1 with vec_real/vec_imag stable, and in_ready SHALL be 0.
REQ-021 In RUN, the first cycle fft_done is sampled 1 SHALL capture core_real/core_imag into output registers, drop fft_start next cycle, and enter DRAIN.
REQ-022 RUN SHALL count cycles; if TIMEOUT cycles elapse without fft_done, the block SHALL set timeout_err, drop fft_start, and enter IDLE.
REQ-023 A core result element i SHALL be taken from bits [formatWidth*(NPOINT-i)-1 : formatWidth*(NPOINT-1-i)], i.e. element 0 is in the MSBs.
REQ-024 DRAIN SHALL present element j (j = 0..NPOINT-1) with out_valid=1, advancing on out_valid&out_ready; outputs SHALL hold while out_ready=0.
REQ-025 out_last SHALL be 1 only with element NPOINT-1; after that transfer the state SHALL go to LOAD and out_valid SHALL drop next cycle.
REQ-026 The block SHALL accept no input while in RUN or DRAIN; a frame in flight SHALL never be overwritten.
REQ-027 fft_done rising in LOAD or DRAIN SHALL be ignored.
REQ-028 Latency: fft_start SHALL rise the cycle after the NPOINT-th input transfer, and out_valid SHALL rise the cycle after capture.
REQ-029 timeout_err SHALL clear only on reset.

Reset
REQ-030 rst=0 SHALL asynchronously force state IDLE, counters 0, fft_start 0, in_ready 0, out_valid 0, out_last 0, timeout_err 0, and vec/capture registers all-zero.
REQ-031 Reset mid-frame SHALL discard all partial input and output data; no transfer completes on the reset cycle.

Configuration
REQ-032 The macro FFT_BITREV_EN SHALL select the DRAIN order: when defined, the j-th emitted sample is element bitreverse(j, log2 NPOINT); when undefined, it is element j (natural order).

Verification
REQ-033 Reset then 32 samples real=k, imag=32+k with in_valid held -> fft_start rises the cycle after sample 31; vec_real bits[8:0]=0 and bits[287:279]=31.
REQ-034 fft_done pulsed 5 cycles into RUN, core_real element i = i -> out_real sequence 0..31, out_last on 31 (FFT_BITREV_EN undefined); with the macro defined -> 0,16,8,24,...
REQ-035 out_ready toggled 1,0,0,1 during DRAIN -> out_real holds across stalls, no skips or duplicates, exactly 32 transfers.
REQ-036 fft_done never asserted, TIMEOUT=16 -> fft_start drops after 16 RUN cycles, timeout_err=1, busy pulses low one cycle, then LOAD resumes.
REQ-037 rst driven low after sample 10 -> all outputs at reset values immediately; the next frame loads from k=0.
REQ-038 NPOINT=4 instance with back-to-back frames -> second frame's in_ready rises the cycle after the first frame's out_last transfer.

Source files
------------

// File: rtl/fft_frame_streamer.sv
// Frame buffer around an FFT core: loads NPOINT samples, runs the core, then streams the result.
// Define FFT_BITREV_EN to emit results in bit-reversed index order instead of natural order.
module fft_frame_streamer #(
    parameter int formatWidth = 9,
    parameter int NPOINT      = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [formatWidth-1:0]        in_real,
    input  logic [formatWidth-1:0]        in_imag,
    output logic [10:0]                   fft_size,
    output logic                          fft_start,
    output logic [NPOINT*formatWidth-1:0] vec_real,
    output logic [NPOINT*formatWidth-1:0] vec_imag,
    input  logic [NPOINT*formatWidth-1:0] core_real,
    input  logic [NPOINT*formatWidth-1:0] core_imag,
    input  logic                          fft_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [formatWidth-1:0]        out_real,
    output logic [formatWidth-1:0]        out_imag,
    output logic                          out_last,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int LOG2 = $clog2(NPOINT);
    localparam int VW   = NPOINT * formatWidth;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [LOG2-1:0] LAST_IDX   = LOG2'(NPOINT - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [LOG2-1:0]        load_cnt_q, load_cnt_d;
    logic [LOG2-1:0]        drain_idx_q, drain_idx_d;
    logic [LOG2-1:0]        drain_nxt;
    logic [TW-1:0]          timer_q, timer_d;
    logic [VW-1:0]          vec_real_q, vec_real_d;
    logic [VW-1:0]          vec_imag_q, vec_imag_d;
    logic [VW-1:0]          cap_real_q, cap_real_d;
    logic [VW-1:0]          cap_imag_q, cap_imag_d;
    logic [formatWidth-1:0] out_real_q, out_real_d;
    logic [formatWidth-1:0] out_imag_q, out_imag_d;
    logic                   in_ready_q, in_ready_d;
    logic                   fft_start_q, fft_start_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   timeout_err_q, timeout_err_d;

    function automatic logic [LOG2-1:0] drain_order(input logic [LOG2-1:0] j);
`ifdef FFT_BITREV_EN
        logic [LOG2-1:0] r;
        for (int b = 0; b < LOG2; b++) begin
            r[b] = j[LOG2-1-b];
        end
        return r;
`else
        return j;
`endif
    endfunction

    // Core vectors carry element 0 in the most significant slot.
    function automatic logic [formatWidth-1:0] element(input logic [VW-1:0] v,
                                                       input logic [LOG2-1:0] i);
        return v[formatWidth*(NPOINT-1-int'(i)) +: formatWidth];
    endfunction

    assign drain_nxt = drain_idx_q + LOG2'(1);

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        drain_idx_d   = drain_idx_q;
        timer_d       = timer_q;
        vec_real_d    = vec_real_q;
        vec_imag_d    = vec_imag_q;
        cap_real_d    = cap_real_q;
        cap_imag_d    = cap_imag_q;
        out_real_d    = out_real_q;
        out_imag_d    = out_imag_q;
        out_last_d    = out_last_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    vec_real_d[formatWidth*int'(load_cnt_q) +: formatWidth] = in_real;
                    vec_imag_d[formatWidth*int'(load_cnt_q) +: formatWidth] = in_imag;
                    if (load_cnt_q == LAST_IDX) begin
                        load_cnt_d = '0;
                        timer_d    = '0;
                        state_d    = RUN;
                    end else begin
                        load_cnt_d = load_cnt_q + LOG2'(1);
                    end
                end
            end
            RUN: begin
                // A completion on the final allowed cycle still wins over the timeout.
                if (fft_done) begin
                    cap_real_d  = core_real;
                    cap_imag_d  = core_imag;
                    drain_idx_d = '0;
                    out_real_d  = element(core_real, drain_order('0));
                    out_imag_d  = element(core_imag, drain_order('0));
                    out_last_d  = 1'b0;
                    state_d     = DRAIN;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (drain_idx_q == LAST_IDX) begin
                        drain_idx_d = '0;
                        out_last_d  = 1'b0;
                        state_d     = LOAD;
                    end else begin
                        drain_idx_d = drain_nxt;
                        out_real_d  = element(cap_real_q, drain_order(drain_nxt));
                        out_imag_d  = element(cap_imag_q, drain_order(drain_nxt));
                        out_last_d  = (drain_nxt == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == LOAD);
        fft_start_d = (state_d == RUN);
        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            load_cnt_q    <= '0;
            drain_idx_q   <= '0;
            timer_q       <= '0;
            vec_real_q    <= '0;
            vec_imag_q    <= '0;
            cap_real_q    <= '0;
            cap_imag_q    <= '0;
            out_real_q    <= '0;
            out_imag_q    <= '0;
            in_ready_q    <= 1'b0;
            fft_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            drain_idx_q   <= drain_idx_d;
            timer_q       <= timer_d;
            vec_real_q    <= vec_real_d;
            vec_imag_q    <= vec_imag_d;
            cap_real_q    <= cap_real_d;
            cap_imag_q    <= cap_imag_d;
            out_real_q    <= out_real_d;
            out_imag_q    <= out_imag_d;
            in_ready_q    <= in_ready_d;
            fft_start_q   <= fft_start_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign fft_size    = 11'(NPOINT);
    assign in_ready    = in_ready_q;
    assign fft_start   = fft_start_q;
    assign vec_real    = vec_real_q;
    assign vec_imag    = vec_imag_q;
    assign out_valid   = out_valid_q;
    assign out_real    = out_real_q;
    assign out_imag    = out_imag_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
